fir_stream: RTL

FIR_STREAM -- requirements
Module: fir_stream

---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_round_sat.sv | 39 +++
 rtl/fir_stream.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : fir_pkg
// Description : Shared constants and helpers for the streaming FIR filter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package fir_pkg;

   localparam int FIR_DEF_NTAPS = 15;

   // Symmetric 15-tap low-pass, Q15-ish scaling (DC gain ~1.1)
   localparam int FIR_DEF_COEF15 [FIR_DEF_NTAPS] = '{
      -413, -886, -1021, -110, 2180, 5360, 8183, 9315,
      8183, 5360, 2180, -110, -1021, -886, -413
   };

   function automatic int fir_acc_w(input int data_w, input int coef_w, input int ntaps);
      return data_w + coef_w + $clog2(ntaps);
   endfunction

   function automatic int fir_def_coef(input int ntaps, input int k);
      if (ntaps == FIR_DEF_NTAPS && k >= 0 && k < FIR_DEF_NTAPS) begin
         return FIR_DEF_COEF15[k[3:0]];
      end
      return 0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fir_round_sat.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : fir_round_sat
// Description : Round-half-up, arithmetic right shift and saturate to OUT_W.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module fir_round_sat #(
   parameter int IN_W  = 36,
   parameter int SHIFT = 0,
   parameter int OUT_W = 32
) (
   input  logic signed [IN_W-1:0]  in_val,
   output logic signed [OUT_W-1:0] out_val,
   output logic                    sat
);

   // One guard bit so the rounding bias can never wrap the input
   localparam int EXT_W = IN_W + 1;
   localparam logic signed [EXT_W-1:0] C_BIAS = (EXT_W'(1) << SHIFT) >> 1;

   logic signed [EXT_W-1:0]     w_rnd;
   logic signed [EXT_W-1:0]     w_shr;
   logic        [EXT_W-OUT_W:0] w_top;

   assign w_rnd = EXT_W'(in_val) + C_BIAS;
   assign w_shr = w_rnd >>> SHIFT;
   assign w_top = w_shr[EXT_W-1:OUT_W-1];
   assign sat   = !((&w_top) || !(|w_top));

   always_comb begin
      out_val = w_shr[OUT_W-1:0];
      if (sat) begin
         out_val = w_shr[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                  : {1'b0, {(OUT_W-1){1'b1}}};
      end
   end

endmodule
`default_nettype wire

// File: rtl/fir_stream.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : fir_stream
// Description : Streaming direct-form FIR, fixed 3-cycle latency, writable taps.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module fir_stream
   import fir_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int NTAPS  = 15,
   parameter int SHIFT  = 0,
   parameter int OUT_W  = 32
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       in_valid,
   input  logic signed [DATA_W-1:0]   in_data,
   input  logic                       clr,
   input  logic                       coef_we,
   input  logic [$clog2(NTAPS)-1:0]   coef_addr,
   input  logic signed [COEF_W-1:0]   coef_data,
   output logic                       out_valid,
   output logic signed [OUT_W-1:0]    out_data,
   output logic                       sat
);

   localparam int ACC_W  = fir_acc_w(DATA_W, COEF_W, NTAPS);
   localparam int PROD_W = DATA_W + COEF_W;

   logic signed [DATA_W-1:0] r_x    [NTAPS];
   logic signed [COEF_W-1:0] r_coef [NTAPS];
   logic signed [PROD_W-1:0] r_prod [NTAPS];
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [ACC_W-1:0]  w_sum;
   logic                     r_v_x;
   logic                     r_v_prod;
   logic                     r_v_acc;
   logic                     r_sat;
   logic                     w_rs_sat;
   logic                     w_sat;

   // Delay line: advances only on accepted samples
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NTAPS; k++) r_x[k] <= '0;
         r_v_x <= 1'b0;
      end else if (clr) begin
         for (int k = 0; k < NTAPS; k++) r_x[k] <= '0;
         r_v_x <= 1'b0;
      end else begin
         r_v_x <= in_valid;
         if (in_valid) begin
            r_x[0] <= in_data;
            for (int k = 1; k < NTAPS; k++) r_x[k] <= r_x[k-1];
         end
      end
   end

   // Coefficients survive clr; out-of-range addresses match no tap
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NTAPS; k++) r_coef[k] <= COEF_W'(fir_def_coef(NTAPS, k));
      end else if (coef_we) begin
         for (int k = 0; k < NTAPS; k++) begin
            if (int'(coef_addr) == k) r_coef[k] <= coef_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NTAPS; k++) r_prod[k] <= '0;
         r_v_prod <= 1'b0;
      end else if (clr) begin
         for (int k = 0; k < NTAPS; k++) r_prod[k] <= '0;
         r_v_prod <= 1'b0;
      end else begin
         r_v_prod <= r_v_x;
         if (r_v_x) begin
            for (int k = 0; k < NTAPS; k++) begin
               r_prod[k] <= PROD_W'(r_x[k]) * PROD_W'(r_coef[k]);
            end
         end
      end
   end

   always_comb begin
      w_sum = '0;
      for (int k = 0; k < NTAPS; k++) w_sum = w_sum + ACC_W'(r_prod[k]);
   end

   // Accumulator only loads on valid data, so out_data holds between pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc   <= '0;
         r_v_acc <= 1'b0;
         r_sat   <= 1'b0;
      end else if (clr) begin
         r_acc   <= '0;
         r_v_acc <= 1'b0;
         r_sat   <= 1'b0;
      end else begin
         r_v_acc <= r_v_prod;
         r_sat   <= w_sat;
         if (r_v_prod) r_acc <= w_sum;
      end
   end

   fir_round_sat #(
      .IN_W  (ACC_W),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
   ) u_round_sat (
      .in_val  (r_acc),
      .out_val (out_data),
      .sat     (w_rs_sat)
   );

   assign w_sat     = r_sat | (r_v_acc & w_rs_sat);
   assign sat       = w_sat;
   assign out_valid = r_v_acc;

endmodule
`default_nettype wire
